maxnet_iter_engine: RTL and testbench

//  Iterative MAXNET winner-take-all engine: loads four unsigned activations, applies lateral inhibition

---
 rtl/maxnet_pkg.sv | 16 +
 rtl/maxnet_neuron_update.sv | 24 ++
 rtl/maxnet_iter_engine.sv | 124 ++++++++++++
 tb/tb_maxnet_iter_engine.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MAXNET winner-take-all engine.
package maxnet_pkg;

  localparam int unsigned W_DEF = 5;
  localparam int unsigned SUM_W = W_DEF + 2;

  typedef logic [1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_e;

endpackage

// File: rtl/maxnet_neuron_update.sv
// One MAXNET neuron: subtracts eps * (sum of the other three), saturating at zero.
module maxnet_neuron_update
  import maxnet_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned EPS_SHIFT = 2
) (
  input  logic [W-1:0] i_self,
  input  logic [W-1:0] i_other0,
  input  logic [W-1:0] i_other1,
  input  logic [W-1:0] i_other2,
  output logic [W-1:0] o_next
);

  logic [W+1:0] w_sum;
  logic [W+1:0] w_dec;

  assign w_sum = {2'b00, i_other0} + {2'b00, i_other1} + {2'b00, i_other2};
  assign w_dec = w_sum >> EPS_SHIFT;

  // When self exceeds the decrement, the decrement fits in W bits.
  assign o_next = ({2'b00, i_self} > w_dec) ? (i_self - w_dec[W-1:0]) : '0;

endmodule

// File: rtl/maxnet_iter_engine.sv
// Iterative MAXNET engine: loads four activations and inhibits until one survives.
// Optional MAXNET_ITER_CNT_EN adds o_iter_count (update count latched at DONE).
module maxnet_iter_engine
  import maxnet_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned EPS_SHIFT = 2,
  parameter int unsigned MAX_ITER  = 31
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_in0,
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in2,
  input  logic [W-1:0] i_in3,
  input  logic         i_dec_done,
  input  idx_t         i_dec_idx,
  output logic [W-1:0] o_a0,
  output logic [W-1:0] o_a1,
  output logic [W-1:0] o_a2,
  output logic [W-1:0] o_a3,
  output logic         o_busy,
  output logic         o_win_valid,
  output idx_t         o_win_idx,
  output logic         o_err
`ifdef MAXNET_ITER_CNT_EN
  ,
  output logic [5:0]   o_iter_count
`endif
);

  state_e              r_state;
  state_e              w_state_next;
  logic [3:0][W-1:0]   r_a;
  logic [3:0][W-1:0]   w_a_next;
  logic [5:0]          r_iter_cnt;
  idx_t                r_win_idx;
  logic                r_err;
  logic                w_all_zero;
  logic                w_timeout;

  for (genvar g = 0; g < 4; g++) begin : g_neuron
    maxnet_neuron_update #(
      .W        (W),
      .EPS_SHIFT(EPS_SHIFT)
    ) u_neuron (
      .i_self  (r_a[g]),
      .i_other0(r_a[(g+1)%4]),
      .i_other1(r_a[(g+2)%4]),
      .i_other2(r_a[(g+3)%4]),
      .o_next  (w_a_next[g])
    );
  end

  assign w_all_zero = (r_a == '0);
  assign w_timeout  = (r_iter_cnt == 6'(MAX_ITER));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_next = LOAD;
      LOAD:    w_state_next = ITER;
      ITER:    if (i_dec_done || w_all_zero || w_timeout) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Decoder verdict takes priority over the error checks and the update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a        <= '0;
      r_iter_cnt <= '0;
      r_win_idx  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_a        <= {i_in3, i_in2, i_in1, i_in0};
        r_iter_cnt <= '0;
      end else if (r_state == ITER) begin
        if (i_dec_done) begin
          r_win_idx <= i_dec_idx;
          r_err     <= 1'b0;
        end else if (w_all_zero || w_timeout) begin
          r_win_idx <= '0;
          r_err     <= 1'b1;
        end else begin
          r_a        <= w_a_next;
          r_iter_cnt <= r_iter_cnt + 6'd1;
        end
      end
    end
  end

`ifdef MAXNET_ITER_CNT_EN
  logic [5:0] r_iter_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iter_count <= '0;
    end else if (r_state == ITER && (i_dec_done || w_all_zero || w_timeout)) begin
      r_iter_count <= r_iter_cnt;
    end
  end

  assign o_iter_count = r_iter_count;
`endif

  assign o_a0        = r_a[0];
  assign o_a1        = r_a[1];
  assign o_a2        = r_a[2];
  assign o_a3        = r_a[3];
  assign o_busy      = (r_state == LOAD) || (r_state == ITER);
  assign o_win_valid = (r_state == DONE);
  assign o_win_idx   = r_win_idx;
  assign o_err       = r_err;

endmodule

// File: tb/tb_maxnet_iter_engine.sv
// Self-checking bench for maxnet_iter_engine with a behavioural one-hot decoder and MAXNET model.
module tb_maxnet_iter_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] in0, in1, in2, in3;
  logic       dec_done;
  logic [1:0] dec_idx;
  logic [4:0] a0, a1, a2, a3;
  logic       busy;
  logic       win_valid;
  logic [1:0] win_idx;
  logic       err;
`ifdef MAXNET_ITER_CNT_EN
  logic [5:0] iter_count;
`endif

  int vectors;
  int miscompares;

  // Model results
  int exp_upd;
  int exp_err;
  int exp_idx;
  int exp_a[4];
  int exp_a1[4];

  maxnet_iter_engine dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_in0      (in0),
    .i_in1      (in1),
    .i_in2      (in2),
    .i_in3      (in3),
    .i_dec_done (dec_done),
    .i_dec_idx  (dec_idx),
    .o_a0       (a0),
    .o_a1       (a1),
    .o_a2       (a2),
    .o_a3       (a3),
    .o_busy     (busy),
    .o_win_valid(win_valid),
    .o_win_idx  (win_idx),
    .o_err      (err)
`ifdef MAXNET_ITER_CNT_EN
    ,
    .o_iter_count(iter_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream one-hot winner decoder
  int dec_nz;
  always_comb begin
    dec_nz  = 0;
    dec_idx = 2'd0;
    if (a0 != 0) begin dec_nz = dec_nz + 1; dec_idx = 2'd0; end
    if (a1 != 0) begin dec_nz = dec_nz + 1; dec_idx = 2'd1; end
    if (a2 != 0) begin dec_nz = dec_nz + 1; dec_idx = 2'd2; end
    if (a3 != 0) begin dec_nz = dec_nz + 1; dec_idx = 2'd3; end
    dec_done = (dec_nz == 1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Inhibition applied literally: each survivor loses a quarter (floored) of the others' total.
  task automatic model(input int i0, input int i1, input int i2, input int i3);
    int a[4];
    int nxt[4];
    int nz;
    int pos;
    int s;
    bit fin;
    a = '{i0, i1, i2, i3};
    exp_upd = 0; exp_err = 0; exp_idx = 0; fin = 0;
    exp_a1 = a;
    for (int k = 0; k < 64 && !fin; k++) begin
      nz = 0; pos = 0;
      for (int i = 0; i < 4; i++) if (a[i] != 0) begin nz++; pos = i; end
      if (nz == 1) begin
        exp_idx = pos; fin = 1;
      end else if (nz == 0 || exp_upd == 31) begin
        exp_err = 1; fin = 1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          s = a[0] + a[1] + a[2] + a[3] - a[i];
          nxt[i] = (a[i] > s / 4) ? a[i] - s / 4 : 0;
        end
        a = nxt;
        exp_upd++;
        if (exp_upd == 1) exp_a1 = a;
      end
    end
    exp_a = a;
  endtask

  task automatic run_case(input string tag, input int i0, input int i1, input int i2,
                          input int i3, input bit busy_start);
    int lat;
    model(i0, i1, i2, i3);
    @(posedge clk); #1;
    in0 = 5'(i0); in1 = 5'(i1); in2 = 5'(i2); in3 = 5'(i3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check({tag, "_busy_load"}, 32'(busy), 32'd1);
    while (!win_valid && lat < 100) begin
      if (busy_start && lat == 2) begin
        in0 = 5'd31; in1 = 5'd31; in2 = 5'd31; in3 = 5'd31; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (lat == 3 && exp_upd >= 1) begin
        check({tag, "_a0_upd1"}, 32'(a0), 32'(exp_a1[0]));
        check({tag, "_a1_upd1"}, 32'(a1), 32'(exp_a1[1]));
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_upd + 3));
    check({tag, "_win_valid"}, 32'(win_valid), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_win_idx"}, 32'(win_idx), 32'(exp_idx));
    check({tag, "_a_final"}, {12'd0, a3, a2, a1, a0},
          {12'd0, 5'(exp_a[3]), 5'(exp_a[2]), 5'(exp_a[1]), 5'(exp_a[0])});
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
`ifdef MAXNET_ITER_CNT_EN
    check({tag, "_iter_count"}, 32'(iter_count), 32'(exp_upd));
`endif
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 32'(win_valid), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; start = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {20'd0, a3, a2, a1, a0, busy, win_valid, win_idx, err}, 32'd0);
    rst_n = 1'b1;

    run_case("spread", 10, 8, 3, 1, 1'b0);
    check("spread_a0_lit", 32'(a0), 32'd5);
    check("spread_upd_lit", 32'(exp_upd), 32'd6);
    run_case("onehot", 0, 0, 17, 0, 1'b0);
    run_case("allzero", 0, 0, 0, 0, 1'b0);
    run_case("tie_timeout", 8, 8, 0, 0, 1'b0);
    check("tie_a0_lit", 32'(a0), 32'd3);
    run_case("all_max", 31, 31, 31, 31, 1'b0);

    // Reset in the middle of a long iteration, then a clean restart.
    @(posedge clk); #1;
    in0 = 5'd8; in1 = 5'd8; in2 = 5'd0; in3 = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_async", {23'd0, a3, a2, a1, a0, busy, win_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", 32'(win_valid | busy), 32'd0);
    end
    run_case("restart", 2, 9, 1, 0, 1'b1);
    check("restart_idx_lit", 32'(win_idx), 32'd1);

    for (int r = 0; r < 8; r++) begin
      run_case("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
